// File: rtl/i2c_xfer_seq.sv
// ---------------------------------------------------------------------------
// i2c_xfer_seq
//   Sequences a complete I2C register transaction (write or read) through a
//   byte-level I2C master. A register write is START+addr(W), reg, data+STOP;
//   a register read is START+addr(W), reg, repeated START+addr(R),
//   read+NACK+STOP. A NACK in the middle of a transfer triggers a STOP-only
//   command so the bus is released before completion is reported.
//
// Ports
//   clk, rst        sole clock, synchronous active-high reset
//   req             start a transaction (sampled only while idle)
//   rnw             1 = register read, 0 = register write
//   sla, rga, wdat  slave address, register address, write data
//   busy            transaction in progress
//   done            one-cycle completion pulse
//   err             0 OK, 1 NACK, 2 arbitration lost, 3 bus busy (held)
//   rdat            read byte, valid with done for a successful read
//   m_cmd/m_dat/m_ws  command, data and write strobe towards the master
//   m_stat/m_dati     master status and read data
//
// Configuration
//   I2C_XFER_SEQ_RETRY_EN  when defined, arbitration-lost and bus-busy
//                          results are retried from the first step after 64
//                          idle cycles, up to 3 attempts in total.
// ---------------------------------------------------------------------------
module i2c_xfer_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rnw,
  input  logic [6:0] sla,
  input  logic [7:0] rga,
  input  logic [7:0] wdat,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [7:0] rdat,
  output logic [4:0] m_cmd,
  output logic [7:0] m_dat,
  output logic       m_ws,
  input  logic [6:0] m_stat,
  input  logic [7:0] m_dati
);

  // Master command bits
  localparam logic [4:0] C_STRT = 5'h01;
  localparam logic [4:0] C_STOP = 5'h02;
  localparam logic [4:0] C_READ = 5'h04;
  localparam logic [4:0] C_WRTE = 5'h08;
  localparam logic [4:0] C_NACK = 5'h10;

  // Master status bit positions
  localparam int unsigned S_DON = 0;
  localparam int unsigned S_ERR = 1;
  localparam int unsigned S_ALO = 2;
  localparam int unsigned S_BBL = 3;
  localparam int unsigned S_ACK = 4;
  localparam int unsigned S_BSY = 5;

`ifdef I2C_XFER_SEQ_RETRY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT, ST_ABORT, ST_ABWT, ST_FIN, ST_RETRY
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT, ST_ABORT, ST_ABWT, ST_FIN
  } state_t;
`endif

  state_t     state, state_n;
  logic       rnw_q;
  logic [6:0] sla_q;
  logic [7:0] rga_q, wdat_q;
  logic [1:0] step, step_n;
  logic [1:0] err_q, err_n;
  logic [7:0] rdat_q, rdat_n;
  logic       in_abort, in_abort_n;
  logic       latch;

`ifdef I2C_XFER_SEQ_RETRY_EN
  logic [1:0] tries, tries_n;
  logic [5:0] wcnt, wcnt_n;
`endif

  logic [4:0] cur_cmd;
  logic [7:0] cur_dat;
  logic       last_step;
  logic       m_idle;
  logic [1:0] code;

  // S_ALO is implied by any S_ERR without S_BBL; bit 6 is unassigned.
  logic unused_stat;
  assign unused_stat = ^{m_stat[6], m_stat[S_ALO]};

  assign m_idle = m_stat[S_DON] & ~m_stat[S_BSY];
  assign err    = err_q;
  assign rdat   = rdat_q;

  // Step table for the current transaction
  always_comb begin
    cur_cmd = '0;
    cur_dat = '0;
    case (step)
      2'd0: begin
        cur_cmd = C_STRT | C_WRTE;
        cur_dat = {sla_q, 1'b0};
      end
      2'd1: begin
        cur_cmd = C_WRTE;
        cur_dat = rga_q;
      end
      2'd2: begin
        if (rnw_q) begin
          cur_cmd = C_STRT | C_WRTE;
          cur_dat = {sla_q, 1'b1};
        end else begin
          cur_cmd = C_WRTE | C_STOP;
          cur_dat = wdat_q;
        end
      end
      default: begin
        cur_cmd = C_READ | C_NACK | C_STOP;
        cur_dat = '0;
      end
    endcase
    last_step = rnw_q ? (step == 2'd3) : (step == 2'd2);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rnw_q    <= 1'b0;
      sla_q    <= '0;
      rga_q    <= '0;
      wdat_q   <= '0;
      step     <= '0;
      err_q    <= '0;
      rdat_q   <= '0;
      in_abort <= 1'b0;
`ifdef I2C_XFER_SEQ_RETRY_EN
      tries    <= '0;
      wcnt     <= '0;
`endif
    end else begin
      state    <= state_n;
      step     <= step_n;
      err_q    <= err_n;
      rdat_q   <= rdat_n;
      in_abort <= in_abort_n;
`ifdef I2C_XFER_SEQ_RETRY_EN
      tries    <= tries_n;
      wcnt     <= wcnt_n;
`endif
      if (latch) begin
        rnw_q  <= rnw;
        sla_q  <= sla;
        rga_q  <= rga;
        wdat_q <= wdat;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n    = state;
    step_n     = step;
    err_n      = err_q;
    rdat_n     = rdat_q;
    in_abort_n = in_abort;
    latch      = 1'b0;
    code       = '0;
`ifdef I2C_XFER_SEQ_RETRY_EN
    tries_n    = tries;
    wcnt_n     = wcnt;
`endif
    case (state)
      ST_IDLE: begin
        if (req) begin
          latch      = 1'b1;
          step_n     = '0;
          err_n      = '0;
          in_abort_n = 1'b0;
`ifdef I2C_XFER_SEQ_RETRY_EN
          tries_n    = '0;
`endif
          state_n    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!m_stat[S_BSY]) state_n = ST_SETTLE;
      end
      // Shared by the normal and the abort path; in_abort picks the wait state.
      ST_SETTLE: begin
        state_n = in_abort ? ST_ABWT : ST_WAIT;
      end
      ST_WAIT: begin
        if (m_idle) begin
          if (m_stat[S_ERR]) begin
            code = m_stat[S_BBL] ? 2'd3 : 2'd2;
`ifdef I2C_XFER_SEQ_RETRY_EN
            if (tries != 2'd2) begin
              tries_n = tries + 2'd1;
              wcnt_n  = '0;
              state_n = ST_RETRY;
            end else begin
              err_n   = code;
              state_n = ST_FIN;
            end
`else
            err_n   = code;
            state_n = ST_FIN;
`endif
          end else if ((cur_cmd & C_WRTE) != '0 && !m_stat[S_ACK]) begin
            // A step carrying STOP has already released the bus.
            err_n   = 2'd1;
            state_n = ((cur_cmd & C_STOP) != '0) ? ST_FIN : ST_ABORT;
          end else if (last_step) begin
            if (rnw_q) rdat_n = m_dati;
            state_n = ST_FIN;
          end else begin
            step_n  = step + 2'd1;
            state_n = ST_ISSUE;
          end
        end
      end
      ST_ABORT: begin
        if (!m_stat[S_BSY]) begin
          in_abort_n = 1'b1;
          state_n    = ST_SETTLE;
        end
      end
      ST_ABWT: begin
        if (m_idle) state_n = ST_FIN;
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
`ifdef I2C_XFER_SEQ_RETRY_EN
      ST_RETRY: begin
        wcnt_n = wcnt + 6'd1;
        if (wcnt == 6'd63) begin
          step_n  = '0;
          state_n = ST_ISSUE;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy  = (state != ST_IDLE) && (state != ST_FIN);
    done  = (state == ST_FIN);
    m_ws  = 1'b0;
    m_cmd = '0;
    m_dat = '0;
    if (state == ST_ISSUE && !m_stat[S_BSY]) begin
      m_ws  = 1'b1;
      m_cmd = cur_cmd;
      m_dat = cur_dat;
    end else if (state == ST_ABORT && !m_stat[S_BSY]) begin
      m_ws  = 1'b1;
      m_cmd = C_STOP;
      m_dat = '0;
    end
  end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter: none; command/status encodings are the codebase I2C command/status bit definitions (C_STRT=0x01, C_STOP=0x02, C_READ=0x04, C_WRTE=0x08, C_NACK=0x10; S_DON=bit0, S_ERR=bit1, S_ALO=bit2, S_BBL=bit3, S_ACK=bit4, S_BSY=bit5).
REQ-002 The block SHALL have exactly one clock and a synchronous, active-high reset; no other clock or reset inputs.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  1  start transaction; sampled only in IDLE.
REQ-006 rnw  in  1  1=register read, 0=register write.
REQ-007 sla  in  7  7-bit slave address.
REQ-008 rga  in  8  register address byte.
REQ-009 wdat  in  8  write data byte.
REQ-010 busy  out  1  transaction in progress (high from cycle after accepted req until done).
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  2  result code, valid with done and held until next accept: 0=OK, 1=NACK, 2=arbitration lost, 3=bus busy.
REQ-013 rdat  out  8  read byte, valid with done when rnw=1 and err=0.
REQ-014 m_cmd  out  5 / m_dat  out  8 / m_ws  out  1  command, data, write-strobe to master.
REQ-015 m_stat  in  7 / m_dati  in  8  master status and read data.

Function
REQ-016 Write transaction step list SHALL be: S0 C_STRT|C_WRTE dat={sla,0}; S1 C_WRTE dat=rga; S2 C_WRTE|C_STOP dat=wdat.
REQ-017 Read transaction step list SHALL be: S0 C_STRT|C_WRTE dat={sla,0}; S1 C_WRTE dat=rga; S2 C_STRT|C_WRTE dat={sla,1}; S3 C_READ|C_NACK|C_STOP.
REQ-018 States: IDLE, ISSUE, SETTLE, WAIT, ABORT, ABWT, FIN.
REQ-019 IDLE: req=1 SHALL latch rnw/sla/rga/wdat, clear step counter, set busy, go ISSUE next cycle.
REQ-020 ISSUE: when m_stat[S_BSY]=0, assert m_ws for exactly one cycle with m_cmd/m_dat of current step, go SETTLE; otherwise hold with m_ws=0.
REQ-021 SETTLE: one cycle, no action (master status update latency), then WAIT.
REQ-022 WAIT: on m_stat[S_DON]=1 and S_BSY=0 evaluate: S_ERR&S_BBL -> err=3, FIN; S_ERR&S_ALO -> err=2, FIN; other S_ERR -> err=1... not used, treated as err=2; write step without STOP and S_ACK=0 -> err=1, ABORT; last step -> FIN with err=0; else step+1, ISSUE.
REQ-023 Last write step (S2 with STOP) with S_ACK=0 SHALL give err=1 without ABORT (STOP already sent).
REQ-024 ABORT: issue C_STOP alone (m_dat=0) via the ISSUE rules, ABWT waits S_DON&!S_BSY, then FIN; err stays 1 even if the stop errors.
REQ-025 FIN: done=1 one cycle, busy=0, rdat=m_dati if read and err=0, go IDLE.
REQ-026 m_ws SHALL never be asserted while m_stat[S_BSY]=1 or outside ISSUE/ABORT.
REQ-027 req while busy SHALL be ignored; req in the FIN cycle is ignored; req in IDLE the cycle after FIN is accepted.
REQ-028 m_cmd and m_dat SHALL be 0 whenever m_ws=0.

Reset
REQ-029 rst=1 SHALL force IDLE, busy=0, done=0, err=0, rdat=0, m_ws=0, m_cmd=0, m_dat=0, step=0, retry count=0, on the next clock edge.
REQ-030 rst mid-transaction SHALL abandon without issuing STOP; master is reset by the same rst.

Configuration
REQ-031 Macro I2C_XFER_SEQ_RETRY_EN defined: on err=2 or err=3 the block SHALL restart from S0 after 64 idle cycles, up to 3 attempts total; done/err reported only after the final attempt; NACK never retried.
REQ-032 Macro undefined: single attempt, err=2/3 go directly to FIN; no retry counter logic present.

Verification
REQ-033 Write sla=0x50 rga=0x10 wdat=0xA5, slave ACKs all -> m_ws cmds 0x09/0xA0, 0x08/0x10, 0x0A/0xA5; done with err=0.
REQ-034 Read sla=0x50 rga=0x02, slave returns 0x3C -> cmds 0x09/0xA0, 0x08/0x02, 0x09/0xA1, 0x16; done with err=0, rdat=0x3C.
REQ-035 Write to absent address 0x21 (no ACK) -> after S0, C_STOP-only command 0x02 issued; done with err=1; exactly 2 m_ws pulses.
REQ-036 Other master holds bus (SDA low, SCL high) at req -> master returns S_ERR|S_BBL|S_DON; without macro done with err=3 and no further m_ws; with macro 3 S0 attempts 64+ cycles apart then err=3.
REQ-037 rst asserted during S1 WAIT -> next cycle busy=0, m_ws=0, IDLE; new req afterwards completes err=0.
REQ-038 req held high continuously for 2 transactions -> second accepted only in IDLE after done; m_ws never coincides with S_BSY=1.
